// File: rtl/memory_test_pkg.sv
// memory_test_pkg: FSM encoding and test pattern shared by the memory test writer and checker.
package memory_test_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;
  function automatic logic [31:0] pattern_word(input logic [31:0] seed, input logic [31:0] step, input logic [31:0] addr);
    return seed + step * addr;
  endfunction
endpackage

// File: rtl/delay_line.sv
// delay_line: width/depth shift register with synchronous reset.
module delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] pipe_q [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end
  assign q_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/ram_pattern_checker.sv
// ram_pattern_checker: sweeps a RAM read port once and checks every word against the arithmetic test pattern.
module ram_pattern_checker
  import memory_test_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    ADDR_WIDTH   = 10,
  parameter int                    READ_LATENCY = 2,
  parameter logic [DATA_WIDTH-1:0] SEED         = '0,
  parameter logic [DATA_WIDTH-1:0] STEP         = DATA_WIDTH'(5)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  renable,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [15:0]           error_count,
  output logic [ADDR_WIDTH-1:0] first_error_addr
);
  localparam int PW = 1 + ADDR_WIDTH + DATA_WIDTH;
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, fea_q, fea_d, t_addr;
  logic [DATA_WIDTH-1:0] exp_q, exp_d, t_exp;
  logic [2:0]            cnt_q, cnt_d;
  logic [15:0]           err_q, err_d;
  logic                  pass_q, pass_d, t_valid, mismatch;
  logic [PW-1:0]         tail;
  // Each issued read carries its address and expected word until its data returns.
  delay_line #(.WIDTH(PW), .DEPTH(READ_LATENCY)) u_pipe (
    .clk(clock),
    .rst(reset),
    .d_i({renable, raddr_q, exp_q}),
    .q_o(tail)
  );
  assign {t_valid, t_addr, t_exp} = tail;
  assign mismatch = t_valid && (rdata != t_exp);
  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fea_d   = fea_q;
    pass_d  = pass_q;
    if (mismatch) begin
      err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
      fea_d = (err_q == 16'd0) ? t_addr : fea_q;
    end
    case (state_q)
      IDLE: if (start) begin
        state_d = READ;
        raddr_d = '0;
        exp_d   = DATA_WIDTH'(pattern_word(32'(SEED), 32'(STEP), 32'd0));
        err_d   = '0;
        fea_d   = '0;
        pass_d  = 1'b0;
      end
      READ: begin
        raddr_d = raddr_q + 1'b1;
        exp_d   = exp_q + STEP;
        cnt_d   = '0;
        state_d = (raddr_q == '1) ? DRAIN : READ;
      end
      DRAIN: begin
        cnt_d   = cnt_q + 3'd1;
        state_d = (cnt_q == 3'(READ_LATENCY - 1)) ? DONE : DRAIN;
      end
      DONE: begin
        pass_d  = (err_q == 16'd0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      raddr_q <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fea_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fea_q   <= fea_d;
      pass_q  <= pass_d;
    end
  end
  assign busy             = state_q != IDLE;
  assign done             = state_q == DONE;
  assign renable          = state_q == READ;
  assign pass             = done ? (err_q == 16'd0) : pass_q;
  assign raddr            = raddr_q;
  assign error_count      = err_q;
  assign first_error_addr = fea_q;
endmodule
